// File: rtl/vga_pkg.sv
// Shared types, default timing and helpers for the VGA timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_e;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_COLOR_W  = 8;
    localparam int unsigned DEF_CNT_W    = 10;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned FRAME_CNT_W  = 8;
    localparam int unsigned NUM_BARS     = 8;
    localparam int unsigned SCROLL_BAR_H = 8;
    localparam int unsigned MIN_CNT_W    = 6;

    function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Half-open window test used for the sync pulses.
    function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                       input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational test-pattern generator: counter position and mode to one pixel colour.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic [CNT_W-1:0]       x,
    input  logic [CNT_W-1:0]       y,
    input  mode_e                  mode,
    input  logic [3*COLOR_W-1:0]   solid_color,
    input  logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [COLOR_W-1:0]     red_c,
    output logic [COLOR_W-1:0]     green_c,
    output logic [COLOR_W-1:0]     blue_c
);

    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

    logic [2:0]           bar_idx;
    logic [5:0]           scroll_line;
    logic                 white;
    logic [3*COLOR_W-1:0] rgb;
    logic                 unused_pos_bits;

    // Only a few bits of y/frame_cnt feed the patterns; fold the rest away.
    assign unused_pos_bits = ^{y, frame_cnt};

    always_comb begin
        bar_idx     = 3'(x / CNT_W'(BAR_W));
        scroll_line = 6'(y) - 6'(frame_cnt);
        white       = 1'b0;
        rgb         = '0;
        case (mode)
            MODE_SOLID:   rgb   = solid_color;
            MODE_BARS:    rgb   = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}},
                                   {COLOR_W{bar_idx[0]}}};
            MODE_CHECKER: white = x[5] ^ y[5];
            MODE_SCROLL:  white = (scroll_line < 6'(SCROLL_BAR_H));
            default:      rgb   = '0;
        endcase
        if (white) begin
            rgb = '1;
        end
    end

    assign {red_c, green_c, blue_c} = rgb;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-enable divider, H/V counters,
// registered sync/blank/colour outputs and a frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_color,
    output logic                   pix_en,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   sync_b,
    output logic                   blank_b,
    output logic [CNT_W-1:0]       x,
    output logic [CNT_W-1:0]       y,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL      = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL      = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_RANGE    = 1 << CNT_W;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((CLK_DIV > 0) ? CLK_DIV - 1 : 0);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    // Reject parameter sets the counters and patterns cannot represent.
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((H_ACTIVE % NUM_BARS) != 0) begin : g_bad_h_active
        $error("vga_timing_gen: H_ACTIVE must be a multiple of 8");
    end
    if ((H_TOTAL > CNT_RANGE) || (V_TOTAL > CNT_RANGE)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (CNT_W < MIN_CNT_W) begin : g_small_cnt_w
        $error("vga_timing_gen: CNT_W must be at least 6 for the patterns");
    end

    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     div_nxt_c;
    logic [CNT_W-1:0]     hcnt_q;
    logic [CNT_W-1:0]     vcnt_q;
    mode_e                mode_q;
    logic [3*COLOR_W-1:0] solid_q;

    logic                 h_last_c;
    logic                 v_last_c;
    logic                 origin_c;
    logic                 active_c;
    logic                 hs_act_c;
    logic                 vs_act_c;
    mode_e                mode_eff_c;
    logic [3*COLOR_W-1:0] solid_eff_c;
    logic [COLOR_W-1:0]   pat_red_c;
    logic [COLOR_W-1:0]   pat_green_c;
    logic [COLOR_W-1:0]   pat_blue_c;

    assign div_nxt_c = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    assign h_last_c = (hcnt_q == H_LAST);
    assign v_last_c = (vcnt_q == V_LAST);
    assign origin_c = (hcnt_q == '0) && (vcnt_q == '0);
    assign active_c = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    assign hs_act_c = in_window(32'(hcnt_q), H_SYNC_START, H_SYNC_END);
    assign vs_act_c = in_window(32'(vcnt_q), V_SYNC_START, V_SYNC_END);

    // At (0,0) the live inputs are used so the first pixel of a frame already
    // shows the mode/colour being latched for the rest of that frame.
    assign mode_eff_c  = origin_c ? mode_e'(mode) : mode_q;
    assign solid_eff_c = origin_c ? solid_color : solid_q;

    vga_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .x           (hcnt_q),
        .y           (vcnt_q),
        .mode        (mode_eff_c),
        .solid_color (solid_eff_c),
        .frame_cnt   (frame_cnt),
        .red_c       (pat_red_c),
        .green_c     (pat_green_c),
        .blue_c      (pat_blue_c)
    );

    assign x      = hcnt_q;
    assign y      = vcnt_q;
    assign sync_b = 1'b0;

    // pix_en trails the divider by one clk so the first pulse after reset
    // lands CLK_DIV clks after release for every divider setting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            pix_en      <= 1'b0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            mode_q      <= MODE_SOLID;
            solid_q     <= '0;
            frame_cnt   <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            blank_b     <= 1'b0;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            div_q  <= div_nxt_c;
            pix_en <= (div_q == DIV_LAST);
            if (pix_en) begin
                hcnt_q <= h_last_c ? '0 : hcnt_q + CNT_W'(1);
                if (h_last_c) begin
                    vcnt_q <= v_last_c ? '0 : vcnt_q + CNT_W'(1);
                end
                if (h_last_c && v_last_c) begin
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                end
                if (origin_c) begin
                    mode_q  <= mode_e'(mode);
                    solid_q <= solid_color;
                end
                hsync       <= hs_act_c ? SYNC_POL : ~SYNC_POL;
                vsync       <= vs_act_c ? SYNC_POL : ~SYNC_POL;
                blank_b     <= active_c;
                frame_start <= origin_c;
                red         <= active_c ? pat_red_c   : '0;
                green       <= active_c ? pat_green_c : '0;
                blue        <= active_c ? pat_blue_c  : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default line 0, a scaled CLK_DIV=2 frame,
// and a tiny CLK_DIV=1 frame run through 257 frames in scroll mode.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] bar_rgb [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    // default-parameter instance
    logic       d_rst_n, d_pe, d_hs, d_vs, d_syncb, d_blank, d_fs;
    logic [1:0] d_mode;
    logic [23:0] d_solid;
    logic [9:0] d_x, d_y;
    logic [7:0] d_r, d_g, d_b, d_fcnt;

    // scaled instance: H 64/4/8/4 (80), V 16/2/2/2 (22), CLK_DIV 2
    logic       m_rst_n, m_pe, m_hs, m_vs, m_syncb, m_blank, m_fs;
    logic [1:0] m_mode;
    logic [23:0] m_solid;
    logic [9:0] m_x, m_y;
    logic [7:0] m_r, m_g, m_b, m_fcnt;

    // tiny instance: H 8/2/2/2 (14), V 4/1/1/1 (7), CLK_DIV 1
    logic       s_rst_n, s_pe, s_hs, s_vs, s_syncb, s_blank, s_fs;
    logic [1:0] s_mode;
    logic [23:0] s_solid;
    logic [9:0] s_x, s_y;
    logic [7:0] s_r, s_g, s_b, s_fcnt;

    vga_timing_gen u_def (
        .clk(clk), .reset_n(d_rst_n), .mode(d_mode), .solid_color(d_solid),
        .pix_en(d_pe), .hsync(d_hs), .vsync(d_vs), .sync_b(d_syncb), .blank_b(d_blank),
        .x(d_x), .y(d_y), .red(d_r), .green(d_g), .blue(d_b),
        .frame_start(d_fs), .frame_cnt(d_fcnt)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_mid (
        .clk(clk), .reset_n(m_rst_n), .mode(m_mode), .solid_color(m_solid),
        .pix_en(m_pe), .hsync(m_hs), .vsync(m_vs), .sync_b(m_syncb), .blank_b(m_blank),
        .x(m_x), .y(m_y), .red(m_r), .green(m_g), .blue(m_b),
        .frame_start(m_fs), .frame_cnt(m_fcnt)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .clk(clk), .reset_n(s_rst_n), .mode(s_mode), .solid_color(s_solid),
        .pix_en(s_pe), .hsync(s_hs), .vsync(s_vs), .sync_b(s_syncb), .blank_b(s_blank),
        .x(s_x), .y(s_y), .red(s_r), .green(s_g), .blue(s_b),
        .frame_start(s_fs), .frame_cnt(s_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line 0 of the default 640x480 timing in colour-bar mode.
    task automatic run_def_line0();
        int hs_low;
        hs_low = 0;
        d_rst_n = 1'b1;
        @(negedge clk);
        check("d_pe_first_early", 32'(d_pe), 32'd0);
        @(negedge clk);
        for (int p = 0; p < 800; p++) begin
            check("d_pe", 32'(d_pe), 32'd1);
            check("d_x", 32'(d_x), 32'(p));
            check("d_y", 32'(d_y), 32'd0);
            @(negedge clk);
            check("d_rgb", 32'({d_r, d_g, d_b}), (p < 640) ? 32'(bar_rgb[(p / 80) % 8]) : 32'd0);
            check("d_blank", 32'(d_blank), 32'(p < 640));
            check("d_hsync", 32'(d_hs), (p >= 656 && p < 752) ? 32'd0 : 32'd1);
            check("d_vsync", 32'(d_vs), 32'd1);
            check("d_fstart", 32'(d_fs), 32'(p == 0));
            check("d_pe_gap", 32'(d_pe), 32'd0);
            if (d_hs == 1'b0) hs_low++;
            @(negedge clk);
        end
        check("d_hsync_width", 32'(hs_low), 32'd96);
        check("d_x_wrap", 32'(d_x), 32'd0);
        check("d_y_line1", 32'(d_y), 32'd1);
        check("d_sync_b", 32'(d_syncb), 32'd0);
    endtask

    // One pixel of the scaled instance, entered on the negedge where pix_en is high.
    task automatic m_pixel(input int hx, input int vy, input int md, input logic [23:0] sol);
        logic [23:0] exp_rgb;
        check("m_pe", 32'(m_pe), 32'd1);
        check("m_x", 32'(m_x), 32'(hx));
        check("m_y", 32'(m_y), 32'(vy));
        @(negedge clk);
        if (hx >= 64 || vy >= 16)        exp_rgb = 24'h000000;
        else if (md == 0)                exp_rgb = sol;
        else if ((((hx / 32) ^ (vy / 32)) & 1) == 1) exp_rgb = 24'hFFFFFF;
        else                             exp_rgb = 24'h000000;
        check("m_rgb", 32'({m_r, m_g, m_b}), 32'(exp_rgb));
        check("m_blank", 32'(m_blank), 32'(hx < 64 && vy < 16));
        check("m_hsync", 32'(m_hs), (hx >= 68 && hx < 76) ? 32'd0 : 32'd1);
        check("m_vsync", 32'(m_vs), (vy >= 18 && vy < 20) ? 32'd0 : 32'd1);
        check("m_fstart", 32'(m_fs), 32'(hx == 0 && vy == 0));
        check("m_pe_gap", 32'(m_pe), 32'd0);
        @(negedge clk);
    endtask

    task automatic m_run(input int md, input logic [23:0] sol, input int n_pix, input int fexp);
        int hx, vy;
        check("m_fcnt", 32'(m_fcnt), 32'(fexp));
        for (int i = 0; i < n_pix; i++) begin
            hx = i % 80;
            vy = i / 80;
            // Change mode and colour mid-frame; the running frame must not see it.
            if (md == 0 && vy == 5 && hx == 10) begin
                m_mode  = 2'd2;
                m_solid = 24'h00FF00;
            end
            m_pixel(hx, vy, md, sol);
        end
    endtask

    task automatic run_mid();
        int unsigned c0, c1;
        m_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        c0 = cyc;
        m_run(0, 24'h123456, 1760, 0);
        c1 = cyc;
        check("m_frame_period", c1 - c0, 32'd3520);
        m_run(2, 24'h000000, 1760, 1);
        m_run(2, 24'h000000, 10 * 80 + 30, 2);
        check("m_pre_rst_x", 32'(m_x), 32'd30);
        check("m_pre_rst_y", 32'(m_y), 32'd10);
        m_rst_n = 1'b0;
        #1;
        check("m_rst_x", 32'(m_x), 32'd0);
        check("m_rst_y", 32'(m_y), 32'd0);
        check("m_rst_fcnt", 32'(m_fcnt), 32'd0);
        check("m_rst_pe", 32'(m_pe), 32'd0);
        check("m_rst_hsync", 32'(m_hs), 32'd1);
        check("m_rst_vsync", 32'(m_vs), 32'd1);
        check("m_rst_blank", 32'(m_blank), 32'd0);
        check("m_rst_rgb", 32'({m_r, m_g, m_b}), 32'd0);
        check("m_rst_fstart", 32'(m_fs), 32'd0);
        @(negedge clk);
        m_rst_n = 1'b1;
        @(negedge clk);
        check("m_rel_pe_early", 32'(m_pe), 32'd0);
        @(negedge clk);
        m_run(2, 24'h000000, 160, 0);
    endtask

    // CLK_DIV=1 instance in scroll mode across the frame-counter wrap.
    task automatic run_small();
        logic [23:0] exp_rgb;
        check("s_rst_pe", 32'(s_pe), 32'd0);
        s_rst_n = 1'b1;
        @(negedge clk);
        for (int f = 0; f <= 256; f++) begin
            check("s_fcnt", 32'(s_fcnt), 32'(f % 256));
            if (f == 256) check("s_fcnt_wrap", 32'(s_fcnt), 32'd0);
            for (int vy = 0; vy < 7; vy++) begin
                for (int hx = 0; hx < 14; hx++) begin
                    check("s_pe", 32'(s_pe), 32'd1);
                    check("s_x", 32'(s_x), 32'(hx));
                    check("s_y", 32'(s_y), 32'(vy));
                    @(negedge clk);
                    if (hx < 8 && vy < 4 && ((vy - f) & 63) < 8) exp_rgb = 24'hFFFFFF;
                    else                                         exp_rgb = 24'h000000;
                    check("s_rgb", 32'({s_r, s_g, s_b}), 32'(exp_rgb));
                    check("s_blank", 32'(s_blank), 32'(hx < 8 && vy < 4));
                    check("s_hsync", 32'(s_hs), (hx >= 10 && hx < 12) ? 32'd0 : 32'd1);
                    check("s_vsync", 32'(s_vs), (vy == 5) ? 32'd0 : 32'd1);
                    check("s_fstart", 32'(s_fs), 32'(hx == 0 && vy == 0));
                end
            end
        end
    endtask

    initial begin
        d_rst_n = 1'b0; d_mode = 2'd1; d_solid = 24'h000000;
        m_rst_n = 1'b0; m_mode = 2'd0; m_solid = 24'h123456;
        s_rst_n = 1'b0; s_mode = 2'd3; s_solid = 24'hABCDEF;
        repeat (3) @(negedge clk);
        check("rst_pe", 32'(d_pe), 32'd0);
        check("rst_hsync", 32'(d_hs), 32'd1);
        check("rst_vsync", 32'(d_vs), 32'd1);
        check("rst_sync_b", 32'(d_syncb), 32'd0);
        check("rst_blank", 32'(d_blank), 32'd0);
        check("rst_rgb", 32'({d_r, d_g, d_b}), 32'd0);
        check("rst_fstart", 32'(d_fs), 32'd0);
        check("rst_fcnt", 32'(d_fcnt), 32'd0);
        check("rst_x", 32'(d_x), 32'd0);
        check("rst_y", 32'(d_y), 32'd0);
        check("rst_pe_div1", 32'(s_pe), 32'd0);
        run_def_line0();
        run_mid();
        run_small();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
